// File: rtl/pong_game_ctrl.sv
// Pong game controller: four-state Moore FSM with two-digit BCD score,
// ball counter and a refresh-tick pause timer.
module pong_game_ctrl #(
  parameter int unsigned BALLS       = 3,
  parameter int unsigned TIMER_TICKS = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] btn,
  input  logic       refr_tick,
  input  logic       hit,
  input  logic       miss,
  output logic [3:0] dig0,
  output logic [3:0] dig1,
  output logic [1:0] ball,
  output logic       gra_still,
  output logic       show_rule,
  output logic       show_over,
  output logic [1:0] state
);

  localparam int unsigned TimerW = 7;
  localparam int unsigned BallW  = 2;
  localparam int unsigned DigW   = 4;

  typedef enum logic [1:0] {
    S_NEWGAME = 2'd0,
    S_PLAY    = 2'd1,
    S_NEWBALL = 2'd2,
    S_OVER    = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [BallW-1:0]    ball_q, ball_d;
  logic [DigW-1:0]     dig0_q, dig0_d;
  logic [DigW-1:0]     dig1_q, dig1_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic                gra_still_q, gra_still_d;
  logic                show_rule_q, show_rule_d;
  logic                show_over_q, show_over_d;
  logic                timer_load;
  logic                inc_score;
  logic                clr_game;
  logic                timer_done;

  assign timer_done = (timer_q == '0);

  // Next-state, timer, score and ball logic
  always_comb begin
    state_d     = state_q;
    ball_d      = ball_q;
    dig0_d      = dig0_q;
    dig1_d      = dig1_q;
    timer_d     = timer_q;
    timer_load  = 1'b0;
    inc_score   = 1'b0;
    clr_game    = 1'b0;

    case (state_q)
      S_NEWGAME: begin
        if (btn != 2'b00) begin
          state_d = S_PLAY;
          if (ball_q != '0) ball_d = ball_q - BallW'(1);
        end
      end
      S_PLAY: begin
        // A miss wins over a same-cycle hit
        if (miss) begin
          timer_load = 1'b1;
          if (ball_q == '0) begin
            state_d = S_OVER;
          end else begin
            state_d = S_NEWBALL;
            ball_d  = ball_q - BallW'(1);
          end
        end else if (hit) begin
          inc_score = 1'b1;
        end
      end
      S_NEWBALL: begin
        if (timer_done && (btn != 2'b00)) state_d = S_PLAY;
      end
      S_OVER: begin
        if (timer_done) begin
          state_d  = S_NEWGAME;
          clr_game = 1'b1;
        end
      end
      default: state_d = S_NEWGAME;
    endcase

    if (timer_load) begin
      timer_d = TimerW'(TIMER_TICKS);
    end else if (refr_tick && !timer_done) begin
      timer_d = timer_q - TimerW'(1);
    end

    if (clr_game) begin
      dig0_d = '0;
      dig1_d = '0;
      ball_d = BallW'(BALLS);
    end else if (inc_score) begin
      if (dig0_q == DigW'(9)) begin
        dig0_d = '0;
        dig1_d = (dig1_q == DigW'(9)) ? '0 : dig1_q + DigW'(1);
      end else begin
        dig0_d = dig0_q + DigW'(1);
      end
    end

    gra_still_d = (state_d != S_PLAY);
    show_rule_d = (state_d == S_NEWGAME);
    show_over_d = (state_d == S_OVER);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_NEWGAME;
      ball_q      <= BallW'(BALLS);
      dig0_q      <= '0;
      dig1_q      <= '0;
      timer_q     <= '0;
      gra_still_q <= 1'b1;
      show_rule_q <= 1'b1;
      show_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ball_q      <= ball_d;
      dig0_q      <= dig0_d;
      dig1_q      <= dig1_d;
      timer_q     <= timer_d;
      gra_still_q <= gra_still_d;
      show_rule_q <= show_rule_d;
      show_over_q <= show_over_d;
    end
  end

  assign dig0      = dig0_q;
  assign dig1      = dig1_q;
  assign ball      = ball_q;
  assign gra_still = gra_still_q;
  assign show_rule = show_rule_q;
  assign show_over = show_over_q;
  assign state     = 2'(state_q);

endmodule

// File: doc/pong_game_ctrl.md
PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

Interface
REQ-001 SHALL provide parameter BALLS, default 3, number of balls per game (legal range 1..3).
REQ-002 SHALL provide parameter TIMER_TICKS, default 120, refresh ticks in the pause timer (2 s at 60 Hz); legal range 1..127.
REQ-003 SHALL provide port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-004 SHALL provide port reset, input, 1, reset that is synchronous and active-high.
REQ-005 SHALL provide port btn, input, 2, debounced paddle buttons; any nonzero value is a "press".
REQ-006 SHALL provide port refr_tick, input, 1, one-cycle pulse at each frame start.
REQ-007 SHALL provide port hit, input, 1, one-cycle pulse when the ball strikes the paddle.
REQ-008 SHALL provide port miss, input, 1, one-cycle pulse when the ball passes the paddle.
REQ-009 SHALL provide port dig0, output, 4, BCD units digit of the score.
REQ-010 SHALL provide port dig1, output, 4, BCD tens digit of the score.
REQ-011 SHALL provide port ball, output, 2, balls remaining, for text display.
REQ-012 SHALL provide port gra_still, output, 1, freezes ball/paddle motion in the graphics stage.
REQ-013 SHALL provide port show_rule, output, 1, selects logo and rule text.
REQ-014 SHALL provide port show_over, output, 1, selects "Game Over" text.
REQ-015 SHALL provide port state, output, 2, encoded FSM state: NEWGAME=0, PLAY=1, NEWBALL=2, OVER=3.

Function
REQ-016 SHALL implement a four-state Moore FSM with states NEWGAME, PLAY, NEWBALL and OVER; all outputs SHALL be registered or decoded from registers only.
REQ-017 In NEWGAME: gra_still=1, show_rule=1, ball=BALLS, score=00; btn!=0 -> PLAY next cycle, with ball decremented by 1 on that same edge.
REQ-018 In PLAY: gra_still=0, show_rule=0, show_over=0; hit increments the score by 1 in BCD.
REQ-019 In PLAY, on miss with ball==0: next state OVER and the timer is loaded.
REQ-020 In PLAY, on miss with ball!=0: next state NEWBALL, ball is decremented, and the timer is loaded.
REQ-021 In PLAY, hit and miss in the same cycle: miss SHALL take priority and the hit SHALL be ignored (score unchanged).
REQ-022 In NEWBALL: gra_still=1; state returns to PLAY only when the timer has expired and btn!=0 in the same cycle; presses before expiry are ignored.
REQ-023 In OVER: gra_still=1, show_over=1; on timer expiry -> NEWGAME; score and ball are reloaded on entry to NEWGAME.
REQ-024 The timer SHALL be a 7-bit down-counter.
REQ-025 The timer SHALL load TIMER_TICKS on the FSM load event.
REQ-026 The timer SHALL decrement only on refr_tick and only while it is nonzero.
REQ-027 Timer expiry is defined as count==0; a load SHALL override a same-cycle decrement.
REQ-028 Score SHALL be two BCD digits.
REQ-029 When dig0==9, an increment SHALL set dig0 to 0 and increment dig1.
REQ-030 When the score is 99, an increment SHALL wrap it to 00.
REQ-031 The digits SHALL never hold a value greater than 9.
REQ-032 The ball counter SHALL never decrement below 0.
REQ-033 hit, miss and refr_tick SHALL be ignored in every state not listed as consuming them.

Reset
REQ-034 While reset=1 at a clock edge, the next state SHALL be NEWGAME with dig0=0, dig1=0, ball=BALLS, timer=0, gra_still=1, show_rule=1, show_over=0, state=0, regardless of other inputs.
REQ-035 Reset asserted during any state, including mid-timer, SHALL abandon the game with no residual timer or score effect.

Verification
REQ-036 SHALL verify start-up: reset 1 cycle, btn=01 -> state PLAY next cycle, ball=2, gra_still=0, score=00.
REQ-037 SHALL verify scoring: 100 hit pulses in PLAY -> dig1/dig0 step through 09->10 and 99->00; final score 00, with 12 hits giving dig1=1, dig0=2.
REQ-038 SHALL verify the miss path: miss with ball=2 -> NEWBALL, ball=1; btn held throughout -> remains NEWBALL until the 120th refr_tick, then PLAY on the next cycle.
REQ-039 SHALL verify game over: miss with ball=0 -> OVER, show_over=1; after 120 refr_ticks -> NEWGAME, score=00, ball=3.
REQ-040 SHALL verify simultaneous hit+miss in PLAY (ball=1, score=05) -> NEWBALL, ball=0, score stays 05.
REQ-041 SHALL verify mid-operation reset: reset in NEWBALL with timer=60 and score=37 -> NEWGAME, score=00, timer=0, ball=3 on the next cycle.
